// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential-multiplier dispatcher.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_e;

   localparam int DEF_W        = 4;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_MULT_LAT = 8;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO: DEPTH entries of DW bits, power-of-2 depth, no bypass.
module op_fifo
   import mult_pkg::*;
#(
   parameter int DW    = 2 * DEF_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DW-1:0]                din,
   output logic [DW-1:0]                dout,
   output logic [clog2(DEPTH+1)-1:0]    count,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CW = clog2(DEPTH + 1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/seq_mult_dispatch.sv
// Feeds operand pairs to a fixed-latency sequential multiplier one at a time
// and returns products downstream in acceptance order.
module seq_mult_dispatch
   import mult_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int MULT_LAT = DEF_MULT_LAT
) (
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [W-1:0]                 in_a,
   input  logic [W-1:0]                 in_b,
   output logic                         mult_start,
   output logic [W-1:0]                 mult_a,
   output logic [W-1:0]                 mult_b,
   input  logic [2*W-1:0]               mult_p,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*W-1:0]               out_p,
   output logic                         busy,
   output logic [clog2(DEPTH+1)-1:0]    fifo_count
);

   localparam int CNT_W = (MULT_LAT > 1) ? clog2(MULT_LAT) : 1;

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [2*W-1:0]   head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   // in_ready comes from the registered count, so a same-cycle pop never frees a slot.
   assign in_ready = !fifo_full;
   assign busy     = (state != IDLE);
   assign pop      = (state == IDLE) && !fifo_empty;

   op_fifo #(.DW(2 * W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clr_n (clr_n),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   ({in_a, in_b}),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= IDLE;
         cnt        <= '0;
         mult_start <= 1'b0;
         mult_a     <= '0;
         mult_b     <= '0;
         out_valid  <= 1'b0;
         out_p      <= '0;
      end else begin
         mult_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  {mult_a, mult_b} <= head;
                  mult_start       <= 1'b1;
                  state            <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= CNT_W'(MULT_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               // Product is valid on mult_p in the cycle the counter reads zero.
               if (cnt == '0) begin
                  out_p     <= mult_p;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_dispatch.sv
// Randomized and directed bench for seq_mult_dispatch with a behavioural multiplier.
module tb_seq_mult_dispatch;

   localparam int W        = 4;
   localparam int DEPTH    = 4;
   localparam int MULT_LAT = 8;

   logic         clk = 1'b0;
   logic         clr_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         mult_start;
   logic [W-1:0] mult_a;
   logic [W-1:0] mult_b;
   logic [7:0]   mult_p = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [7:0]   out_p;
   logic         busy;
   logic [2:0]   fifo_count;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] expq[$];
   logic       prev_start = 1'b0;
   int         mc = -1;
   logic [7:0] prod = '0;

   seq_mult_dispatch #(.W(W), .DEPTH(DEPTH), .MULT_LAT(MULT_LAT)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mult_start (mult_start),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_p     (mult_p),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Multiplier model: product on mult_p during cycle L+MULT_LAT only, noise otherwise.
   always @(negedge clk) begin
      if (!clr_n) mc = -1;
      else if (mult_start) begin
         prod = 8'(mult_a) * 8'(mult_b);
         mc   = MULT_LAT;
      end else if (mc >= 0) mc--;
      mult_p = (mc == 0) ? prod : 8'($urandom);
   end

   // Scoreboard: every accepted pair yields its product, in order.
   always @(negedge clk) begin
      if (clr_n) begin
         if (mult_start) chk("start_pulse", prev_start, 0);
         if (in_valid && in_ready) expq.push_back(8'(in_a) * 8'(in_b));
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("out_unexpected", out_valid, 0);
            else chk("out_p", out_p, expq.pop_front());
         end
      end
      prev_start = mult_start;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("push_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!out_valid && n < bound) begin
         step();
         n++;
      end
      chk("wait_valid", out_valid, 1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((expq.size() != 0 || busy || fifo_count != 0) && n < 300) begin
         step();
         n++;
      end
      chk(tag, expq.size(), 0);
   endtask

   // Push one pair into an idle, empty dispatcher and check the exact timeline.
   task automatic check_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [7:0] p);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = 1'b1;
      chk("lat_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         chk("lat_start", mult_start, k == 2);
         if (k == 2) begin
            chk("lat_a", mult_a, a);
            chk("lat_b", mult_b, b);
         end
         chk("lat_valid", out_valid, k == 11);
         if (k == 11) chk("lat_p", out_p, p);
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, count %0d", n_bad);
      $fatal(1);
   end

   initial begin
      int got;
      int last;
      logic acc;

      // Reset
      repeat (3) @(posedge clk);
      #1 clr_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_start", mult_start, 0);
      chk("rst_mult_a", mult_a, 0);
      chk("rst_mult_b", mult_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      step();

      // Single pair latency
      check_latency(4'd2, 4'd4, 8'd8);
      step();

      // Fill and backpressure
      out_ready = 1'b0;
      push(4'd4, 4'd7);
      push(4'd15, 4'd15);
      push(4'd0, 4'd9);
      push(4'd1, 4'd1);
      push(4'd3, 4'd5);
      in_valid = 1'b1;
      in_a = 4'd6;
      in_b = 4'd6;
      wait_valid(20);
      chk("full_count", fifo_count, 4);
      chk("full_ready", in_ready, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_p", out_p, 28);
         chk("hold_start", mult_start, 0);
         chk("hold_ready", in_ready, 0);
      end

      // Drain order and throughput; the held sixth pair goes in once space appears
      out_ready = 1'b1;
      got  = 0;
      last = 0;
      for (int n = 0; n < 100 && got < 6; n++) begin
         if (out_valid) begin
            if (got > 0) chk("drain_gap", cyc - last, 11);
            last = cyc;
            got++;
         end
         acc = in_valid && in_ready;
         step();
         if (acc) in_valid = 1'b0;
      end
      chk("drain_count", got, 6);
      drain("drain_empty");

      // Simultaneous push and pop with two entries queued
      out_ready = 1'b0;
      push(4'd5, 4'd3);
      push(4'd9, 4'd9);
      push(4'd2, 4'd7);
      wait_valid(20);
      chk("simul_pre_count", fifo_count, 2);
      out_ready = 1'b1;
      step();
      chk("simul_idle", busy, 0);
      chk("simul_count_a", fifo_count, 2);
      in_valid = 1'b1;
      in_a = 4'd11;
      in_b = 4'd13;
      step();
      in_valid = 1'b0;
      chk("simul_count_b", fifo_count, 2);
      drain("simul_drain");

      // Reset during WAIT abandons the in-flight product
      push(4'd15, 4'd15);
      push(4'd7, 4'd7);
      repeat (4) step();
      chk("mid_busy", busy, 1);
      clr_n = 1'b0;
      expq.delete();
      #1;
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      step();
      clr_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("mid_no_valid", out_valid, 0);
         step();
      end
      check_latency(4'd2, 4'd3, 8'd6);
      step();

      // Random traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_a      = 4'($urandom);
         in_b      = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_mult_dispatch.md
Name: seq_mult_dispatch

Overview:
Upstream feeder and result collector for the sequential 4x4 multiplier (Seq_Mult).
- Accepts operand pairs over a valid/ready interface into a small FIFO.
- Launches one multiplication at a time with a single-cycle start pulse, holding the operands stable throughout.
- After a fixed latency, captures the product and presents it downstream over valid/ready.
- Order-preserving: exactly one result per accepted pair, in acceptance order.

Parameters:
W, 4, operand width; product width is 2*W.
DEPTH, 4, operand FIFO depth; power of 2, at least 2.
MULT_LAT, 8, multiplier latency in cycles: the product is valid on mult_p at the end of cycle L+MULT_LAT, where L is the start cycle; at least 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
clr_n  in  1  asynchronous, active-low reset.
in_valid  in  1  an operand pair is offered.
in_ready  out  1  FIFO not full.
in_a  in  W  operand a.
in_b  in  W  operand b.
mult_start  out  1  one-cycle start pulse to the multiplier.
mult_a  out  W  operand a to the multiplier.
mult_b  out  W  operand b to the multiplier.
mult_p  in  2W  product from the multiplier.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_p  out  2W  result product.
busy  out  1  state is not IDLE.
fifo_count  out  $clog2(DEPTH+1)  current number of FIFO entries.

Behaviour:
Reset (clr_n low, asynchronous):
- FIFO emptied; FSM goes to IDLE; multiplication counter cleared.
- All outputs 0, except in_ready = 1.
- Any in-flight multiplication is abandoned and produces no result.
Input side:
- Push when in_valid && in_ready.
- in_ready = (fifo_count != DEPTH), computed from registered count only. A pop in the same cycle does not free a slot for a push while full.
- Simultaneous push and pop when not full: fifo_count unchanged.
FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, pop the head, load mult_a/mult_b, go to LAUNCH. No bypass: a pair pushed into an empty FIFO is popped the following cycle.
- LAUNCH: mult_start = 1 for exactly this cycle; load counter with MULT_LAT-1; go to WAIT.
- WAIT: counter decrements each cycle. When the counter is 0, register mult_p into out_p, set out_valid, go to HOLD.
- HOLD: out_valid and out_p are held stable until out_ready. On the handshake cycle, clear out_valid and go to IDLE. No new launch while in HOLD.
Operand registers:
- mult_a/mult_b change only on a pop; they are stable from LAUNCH until the next pop.
Latency:
- Pair accepted in cycle T into an empty FIFO with the FSM in IDLE: mult_start in cycle T+2; out_valid first high in cycle T+MULT_LAT+3.
- Default (MULT_LAT = 8): T+11.
Throughput:
- One result per MULT_LAT+3 cycles, given out_ready = 1.
Widths:
- out_p is the full 2W product; there is no truncation.
Pulse rule:
- mult_start is never high in two consecutive cycles.

Decomposition:
Package mult_pkg holds:
- state enum {IDLE, LAUNCH, WAIT, HOLD};
- default constants W = 4, DEPTH = 4, MULT_LAT = 8;
- function clog2.
Sub-module op_fifo:
- synchronous FIFO of {a, b}, 2W bits wide, DEPTH entries;
- ports push, pop, din, dout, count, full, empty;
- same asynchronous active-low reset.
The FSM and counter live in seq_mult_dispatch.

Test Plan:
Bench uses a behavioural multiplier model that drives mult_p = mult_a*mult_b MULT_LAT cycles after mult_start; MULT_LAT = 8 in all scenarios.
1. Reset: clr_n low for 3 cycles, then high -> all outputs 0, in_ready = 1, fifo_count = 0, busy = 0.
2. Single pair: push a=2, b=4 in cycle T -> mult_start high only in T+2 with mult_a=2, mult_b=4; out_valid high at T+11 with out_p = 8.
3. Fill and backpressure: out_ready = 0; push 4x7, 15x15, 0x9, 1x1, 3x5, 6x6 on consecutive cycles -> first result 28 held in HOLD; fifo_count reaches 4 and in_ready = 0; the sixth pair is held until space; out_p and out_valid are stable over 20 stalled cycles with no further mult_start.
4. Drain order: release out_ready -> results 28, 225, 0, 1, 15, 36, in order, one per 11 cycles.
5. Simultaneous push and pop: with fifo_count = 2 in IDLE, push in the same cycle as the pop -> fifo_count stays 2.
6. Reset mid-operation: pull clr_n low during WAIT of 15x15 -> out_valid never asserted for that pair; fifo_count = 0; after release a push of 2x3 yields out_p = 6 at T+11.
